// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
//
// Hardware LIFO stack for the multicycle stack processor. The core pushes
// operands/results and pops operands; popped words are registered and appear
// on data_out on the same edge that performs the pop.
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk        in   1        system clock, rising edge
//   resetN     in   1        asynchronous, active-low reset
//   push       in   1        write data_in onto top of stack this edge
//   pop        in   1        remove top of stack this edge, word to data_out
//   data_in    in   WIDTH    word to push
//   data_out   out  WIDTH    last popped word (registered)
//   full       out  1        count == DEPTH
//   empty      out  1        count == 0
//   count      out  AW+1     number of valid entries, 0..DEPTH
//   overflow   out  1        sticky: a push was refused while full
//   underflow  out  1        sticky: a pop was refused while empty
// -----------------------------------------------------------------------------
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] SP_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_EMPTY = '0;

    // Stack pointer doubles as the occupancy count; entries live in
    // mem[0..sp-1] with the top of stack at mem[sp-1].
    logic [AW:0]      sp;
    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic             is_full;
    logic             is_empty;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    next_idx;

    // Decoded operation for this edge.
    logic             replace_top;
    logic             push_ok;
    logic             pop_ok;
    logic             sp_inc;
    logic             sp_dec;
    logic             set_overflow;
    logic             set_underflow;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;

    // Status decodes come from the registered pointer only, so no input
    // has a combinational path to an output.
    assign is_full  = (sp == SP_FULL);
    assign is_empty = (sp == SP_EMPTY);

    // When sp == DEPTH the low AW bits are zero, so subtracting one wraps to
    // DEPTH-1, which is exactly the top entry. When empty, top_idx is unused.
    assign top_idx  = sp[AW-1:0] - 1'b1;
    assign next_idx = sp[AW-1:0];

    always_comb begin
        replace_top   = 1'b0;
        push_ok       = 1'b0;
        pop_ok        = 1'b0;
        sp_inc        = 1'b0;
        sp_dec        = 1'b0;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = next_idx;

        unique case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    set_overflow = 1'b1;
                end else begin
                    push_ok = 1'b1;
                    sp_inc  = 1'b1;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    set_underflow = 1'b1;
                end else begin
                    pop_ok = 1'b1;
                    sp_dec = 1'b1;
                end
            end
            2'b11: begin
                if (is_empty) begin
                    // Nothing to pop: the push still goes ahead as a plain push.
                    set_underflow = 1'b1;
                    push_ok       = 1'b1;
                    sp_inc        = 1'b1;
                end else begin
                    // Replace-top: read the old top and overwrite it in the
                    // same edge; depth is unchanged, so full is no obstacle.
                    replace_top = 1'b1;
                    pop_ok      = 1'b1;
                end
            end
            default: ;
        endcase

        if (replace_top) begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
        end else if (push_ok) begin
            wr_en   = 1'b1;
            wr_addr = next_idx;
        end
    end

    // Control state: pointer, popped-word register and sticky error flags.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sp        <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (sp_inc) begin
                sp <= sp + 1'b1;
            end else if (sp_dec) begin
                sp <= sp - 1'b1;
            end

            // Reads the pre-edge contents, so replace-top returns the old top.
            if (pop_ok) begin
                data_out <= mem[top_idx];
            end

            if (set_overflow) begin
                overflow <= 1'b1;
            end
            if (set_underflow) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage array is deliberately not reset; its contents are don't-care
    // until written. Writes are qualified by resetN so an operation in flight
    // during reset leaves no trace.
    always_ff @(posedge clk) begin
        if (wr_en && resetN) begin
            mem[wr_addr] <= data_in;
        end
    end

    assign full  = is_full;
    assign empty = is_empty;
    assign count = sp;

endmodule
